// File: rtl/div32_seq.sv
// Sequential restoring divider: signed or unsigned, one quotient bit per clock.
// Latency: done after DATA_WIDTH+1 edges past the accepting edge; divide-by-zero finishes on the accepting edge.
// Backpressure: none; start is ignored while busy or during the done cycle.
//
// Ports:
//   clock, clear_n            - rising-edge clock, async active-low reset
//   start, signed_op          - request pulse and mode, sampled only in IDLE
//   dividend, divisor         - operands, sampled with start
//   busy, done                - busy in ITER/FIX, one-cycle done pulse
//   quotient, remainder       - registered results, held until the next result
//   div_zero                  - registered, set when the divisor was zero
module div32_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_quo;      // working dividend, becomes the quotient bit by bit
  logic [DATA_WIDTH-1:0] r_prem;     // partial remainder
  logic [DATA_WIDTH-1:0] r_dvs;      // divisor magnitude
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_signed;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic                  r_div_zero;

  logic [DATA_WIDTH-1:0] w_dvd_abs;
  logic [DATA_WIDTH-1:0] w_dvs_abs;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_ge;
  logic                  w_last;

  assign w_dvd_abs = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_abs = (signed_op && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

  // Partial remainder stays below the divisor, so the shifted value fits in
  // DATA_WIDTH+1 bits and the trial difference lies strictly within +/-divisor:
  // its top bit is a valid sign.
  assign w_shift = {r_prem, r_quo[DATA_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[DATA_WIDTH];
  assign w_last  = (r_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_prem      <= '0;
      r_dvs       <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_signed    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_div_zero  <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_quo    <= w_dvd_abs;
              r_prem   <= '0;
              r_dvs    <= w_dvs_abs;
              r_sign_a <= dividend[DATA_WIDTH-1];
              r_sign_b <= divisor[DATA_WIDTH-1];
              r_signed <= signed_op;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_prem <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
          r_quo  <= {r_quo[DATA_WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder follows the dividend.
          r_quotient  <= (r_signed && (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
          r_remainder <= (r_signed && r_sign_a) ? -r_prem : r_prem;
          r_div_zero  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: vector table plus hand-written multi-cycle sequences.
// Latency: measured in clock edges from the accepting edge to done.
// Backpressure: none; outputs sampled 1 time unit after each rising edge.
module tb_div32_seq;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div32_seq #(.DATA_WIDTH(32)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. lat = edges after the accepting edge.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic z, output int lat);
    @(posedge clock); #1;
    start = 1'b1; signed_op = sg; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    q = quotient; r = remainder; z = div_zero;
  endtask

  initial begin
    logic [31:0] q, r;
    logic        z;
    int          lat;
    int          pulses;
    int          first_done;
    logic [31:0] q_at_done, r_at_done;
    logic        busy_mid, busy_at_done;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    vecs[2]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 33};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    vecs[10] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[11] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 0};
    vecs[12] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 33};

    clear_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", {31'd0, div_zero}, 32'd0);
    @(posedge clock); #1;
    clear_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_div(vecs[i].sg, vecs[i].a, vecs[i].b, q, r, z, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      chk($sformatf("v%0d_z", i), {31'd0, z}, {31'd0, vecs[i].z});
      @(posedge clock); #1;
      chk($sformatf("v%0d_done_fall", i), {31'd0, done}, 32'd0);
    end

    // Start re-pulsed with new operands mid-ITER must be ignored.
    @(posedge clock); #1;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    pulses = 0; first_done = -1; busy_mid = 1'b0; busy_at_done = 1'b1;
    q_at_done = '0; r_at_done = '0;
    for (int c = 0; c < 45; c++) begin
      if (c == 5) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (c == 2) busy_mid = busy;
      if (done) begin
        pulses++;
        if (first_done < 0) begin
          first_done = c; q_at_done = quotient; r_at_done = remainder; busy_at_done = busy;
        end
      end
      @(posedge clock); #1;
    end
    chk("ign_busy_mid", {31'd0, busy_mid}, 32'd1);
    chk("ign_lat", first_done, 33);
    chk("ign_pulses", pulses, 1);
    chk("ign_q", q_at_done, 32'd14);
    chk("ign_r", r_at_done, 32'd2);
    chk("ign_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    chk("hold_q", quotient, 32'd14);
    chk("hold_r", remainder, 32'd2);

    // Reset mid-ITER aborts without done; the next operation runs normally.
    @(posedge clock); #1;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    clear_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_z", {31'd0, div_zero}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    clear_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    chk("abort_no_done", pulses, 0);
    do_div(1'b0, 32'd100, 32'd7, q, r, z, lat);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_q", q, 32'd14);
    chk("post_rst_r", r, 32'd2);
    chk("post_rst_z", {31'd0, z}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
